// File: rtl/pc_branch_unit.sv
// Program counter and control-flow decode for the 4-bit datapath, with a RUN/HALT retire gate.
// Optional return stack for CALL/RET is built when CALL_STACK_EN is defined.
module pc_branch_unit #(
    parameter logic [3:0] RESET_PC    = 4'h0,
    parameter int         STACK_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       step,
    input  logic [3:0] op,
    input  logic [3:0] imm,
    input  logic       zf,
    output logic [3:0] pc,
    output logic       halted,
    output logic       wrap,
    output logic       stk_err
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] pc_q, pc_d;
    logic [3:0] pc_inc;
    logic       wrap_q, wrap_d;
    logic       use_inc;

    assign pc_inc = pc_q + 4'd1;

    generate
        if (STACK_DEPTH < 1 || STACK_DEPTH > 8) begin : g_bad_depth
            $error("pc_branch_unit: STACK_DEPTH must be 1..8");
        end
    endgenerate

`ifdef CALL_STACK_EN
    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [SP_W-1:0]  sp_q, sp_d;
    logic             stk_err_q, stk_err_d;
    logic             push_en;
    logic [IDX_W-1:0] push_idx, top_idx;
    logic [3:0]       stack_q [0:(1 << IDX_W)-1];

    assign push_idx = IDX_W'(sp_q);
    assign top_idx  = IDX_W'(sp_q - SP_W'(1));
`endif

    always_comb begin
        pc_d    = pc_q;
        state_d = state_q;
        use_inc = 1'b0;
`ifdef CALL_STACK_EN
        sp_d      = sp_q;
        stk_err_d = stk_err_q;
        push_en   = 1'b0;
`endif
        if (state_q == RUN && step) begin
            case (op)
                4'hF: pc_d = imm;
                4'hE: if (zf) pc_d = imm; else use_inc = 1'b1;
                4'hD: if (!zf) pc_d = imm; else use_inc = 1'b1;
                4'hC: state_d = HALT;
`ifdef CALL_STACK_EN
                4'hA: begin
                    if (sp_q == SP_W'(STACK_DEPTH)) begin
                        use_inc   = 1'b1;
                        stk_err_d = 1'b1;
                    end else begin
                        push_en = 1'b1;
                        sp_d    = sp_q + SP_W'(1);
                        pc_d    = imm;
                    end
                end
                4'hB: begin
                    if (sp_q == '0) begin
                        use_inc   = 1'b1;
                        stk_err_d = 1'b1;
                    end else begin
                        pc_d = stack_q[top_idx];
                        sp_d = sp_q - SP_W'(1);
                    end
                end
`endif
                default: use_inc = 1'b1;
            endcase
        end
        if (use_inc) pc_d = pc_inc;
        // Only the sequential increment path reports a wrap; jumps to 0 do not.
        wrap_d = use_inc && (pc_q == 4'hF);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            pc_q    <= RESET_PC;
            wrap_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            wrap_q  <= wrap_d;
        end
    end

`ifdef CALL_STACK_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sp_q      <= '0;
            stk_err_q <= 1'b0;
        end else begin
            sp_q      <= sp_d;
            stk_err_q <= stk_err_d;
        end
    end

    // Entries are only read below the stack pointer, so they need no reset.
    always_ff @(posedge clk) begin
        if (push_en) stack_q[push_idx] <= pc_inc;
    end

    assign stk_err = stk_err_q;
`else
    assign stk_err = 1'b0;
`endif

    assign pc     = pc_q;
    assign halted = (state_q == HALT);
    assign wrap   = wrap_q;

endmodule

// File: tb/tb_pc_branch_unit.sv
// Directed self-checking bench for pc_branch_unit; stack section active when CALL_STACK_EN is defined.
`timescale 1ns/1ps
module tb_pc_branch_unit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       step;
    logic [3:0] op;
    logic [3:0] imm;
    logic       zf;
    logic [3:0] pc;
    logic       halted;
    logic       wrap;
    logic       stk_err;

    int n_chk  = 0;
    int n_pass = 0;

    pc_branch_unit #(
        .RESET_PC   (4'h0),
        .STACK_DEPTH(2)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .step   (step),
        .op     (op),
        .imm    (imm),
        .zf     (zf),
        .pc     (pc),
        .halted (halted),
        .wrap   (wrap),
        .stk_err(stk_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic instr(input logic s, input logic [3:0] o, input logic [3:0] i, input logic z);
        step = s; op = o; imm = i; zf = z;
        tick();
    endtask

    int wraps;

    initial begin
        rst_n = 1'b0; step = 1'b0; op = 4'h0; imm = 4'h0; zf = 1'b0;
        #12;
        chk("rst_pc", pc, 4'h0);
        chk("rst_halted", halted, 1'b0);
        chk("rst_wrap", wrap, 1'b0);
        chk("rst_stk_err", stk_err, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        // Sequential run through the wrap
        wraps = 0;
        for (int k = 1; k <= 17; k++) begin
            instr(1'b1, 4'h0, 4'h0, 1'b0);
            chk($sformatf("seq_pc%0d", k), pc, k % 16);
            chk($sformatf("seq_wrap%0d", k), wrap, (k == 16));
            if (wrap) wraps++;
        end
        chk("wrap_count", wraps, 1);

        // Conditional branches from pc=3
        instr(1'b1, 4'h0, 4'h0, 1'b0);
        instr(1'b1, 4'h0, 4'h0, 1'b0);
        chk("pc_at3", pc, 4'h3);
        instr(1'b1, 4'hE, 4'h9, 1'b1); chk("jz_taken", pc, 4'h9);
        instr(1'b1, 4'hF, 4'h3, 1'b0); chk("jmp3_a", pc, 4'h3);
        instr(1'b1, 4'hE, 4'h9, 1'b0); chk("jz_not", pc, 4'h4);
        instr(1'b1, 4'hF, 4'h3, 1'b0);
        instr(1'b1, 4'hD, 4'h9, 1'b1); chk("jnz_not", pc, 4'h4);
        instr(1'b1, 4'hF, 4'h3, 1'b0);
        instr(1'b1, 4'hD, 4'h9, 1'b0); chk("jnz_taken", pc, 4'h9);

        // Stall
        for (int k = 0; k < 5; k++) begin
            instr(1'b0, 4'hF, 4'h7, 1'b0);
            chk($sformatf("stall_pc%0d", k), pc, 4'h9);
            chk($sformatf("stall_wrap%0d", k), wrap, 1'b0);
        end
        instr(1'b1, 4'hF, 4'h7, 1'b0); chk("after_stall", pc, 4'h7);

        // Jump to 0 from 15 must not wrap; self-loop
        instr(1'b1, 4'hF, 4'hF, 1'b0); chk("jmp15", pc, 4'hF);
        instr(1'b1, 4'hF, 4'hF, 1'b0); chk("self_loop", pc, 4'hF);
        instr(1'b1, 4'hF, 4'h0, 1'b0);
        chk("jmp0_pc", pc, 4'h0);
        chk("jmp0_wrap", wrap, 1'b0);
        instr(1'b1, 4'hE, 4'h0, 1'b0);
        chk("jz_not_from0", pc, 4'h1);

        // Halt and async reset out of it
        instr(1'b1, 4'hF, 4'h5, 1'b0); chk("jmp5", pc, 4'h5);
        instr(1'b1, 4'hC, 4'h0, 1'b0);
        chk("hlt_pc", pc, 4'h5);
        chk("hlt_halted", halted, 1'b1);
        for (int k = 0; k < 10; k++) begin
            instr(1'b1, 4'hF, 4'h2, 1'b0);
            chk($sformatf("halt_pc%0d", k), pc, 4'h5);
        end
        chk("halt_still", halted, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("async_pc", pc, 4'h0);
        chk("async_halted", halted, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        instr(1'b1, 4'h0, 4'h0, 1'b0); chk("post_rst_run", pc, 4'h1);

`ifdef CALL_STACK_EN
        instr(1'b1, 4'hA, 4'h4, 1'b0); chk("call1", pc, 4'h4);
        instr(1'b1, 4'hA, 4'h8, 1'b0); chk("call2", pc, 4'h8);
        chk("err_before", stk_err, 1'b0);
        instr(1'b1, 4'hA, 4'hC, 1'b0);
        chk("call_full_pc", pc, 4'h9);
        chk("call_full_err", stk_err, 1'b1);
        instr(1'b0, 4'hB, 4'h0, 1'b0); chk("ret_stall", pc, 4'h9);
        instr(1'b1, 4'hB, 4'h0, 1'b0); chk("ret1", pc, 4'h5);
        instr(1'b1, 4'hB, 4'h0, 1'b0); chk("ret2", pc, 4'h2);
        instr(1'b1, 4'hB, 4'h0, 1'b0);
        chk("ret_empty_pc", pc, 4'h3);
        chk("ret_empty_err", stk_err, 1'b1);
`else
        instr(1'b1, 4'hA, 4'h4, 1'b0); chk("call_nop", pc, 4'h2);
        instr(1'b1, 4'hB, 4'h0, 1'b0); chk("ret_nop", pc, 4'h3);
        chk("no_stk_err", stk_err, 1'b0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
